pmu_quota_sched: RTL and testbench

PMU_QUOTA_SCHED -- requirements
Module: pmu_quota_sched

---
 rtl/pmu_quota_sched.sv | 216 +++++++++++++++++++++
 tb/tb_pmu_quota_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_quota_sched.sv
`default_nettype none
// ============================================================================
// Module   : pmu_quota_sched
// Brief    : Round-robin quota checker. One shared accumulator sweeps the
//            cores in turn. For each core it sums the masked event counters
//            and raises a sticky interrupt when the sum exceeds that core's
//            limit.
// Option   : PMU_QUOTA_SKIP_EMPTY_EN - when defined, a core with an all-zero
//            mask is skipped in a single CLR cycle.
// Revision : 1.0 - initial release
// ============================================================================
module pmu_quota_sched #(
  parameter int  REG_WIDTH  = 32,
  parameter int  N_COUNTERS = 9,
  parameter int  N_CORES    = 4,
  localparam int SW         = $clog2(N_COUNTERS) + REG_WIDTH,
  localparam int CW         = ($clog2(N_CORES) > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic                                  softrst_i,
  input  logic                                  en_i,
  input  logic [N_CORES*N_COUNTERS*REG_WIDTH-1:0] counter_value_i,
  input  logic [N_CORES*N_COUNTERS-1:0]         quota_mask_i,
  input  logic [N_CORES*SW-1:0]                 quota_limit_i,
  input  logic [N_CORES-1:0]                    intr_clr_i,
  output logic [N_CORES-1:0]                    intr_quota_o,
  output logic [CW-1:0]                         cur_core_o,
  output logic                                  sweep_done_o
);

  localparam int IW = ($clog2(N_COUNTERS) > 1) ? $clog2(N_COUNTERS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_CMP  = 2'd3;

  localparam logic [CW-1:0] LAST_CORE = CW'(N_CORES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_COUNTERS - 1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         core_q, core_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         acc_q, acc_d;
  logic [N_COUNTERS-1:0] mask_q, mask_d;
  logic [N_CORES-1:0]    intr_q, intr_d;

  logic [N_COUNTERS-1:0] live_mask;
  logic [SW-1:0]         live_limit;
  logic [REG_WIDTH-1:0]  live_value;
  logic                  mask_bit;
  logic                  mask_chg;
  logic                  over_limit;
  logic [CW-1:0]         core_inc;
`ifdef PMU_QUOTA_SKIP_EMPTY_EN
  logic                  mask_empty;
`endif

  // Select the operands for the current core and counter index
  always_comb begin
    live_mask  = '0;
    live_limit = '0;
    live_value = '0;
    mask_bit   = 1'b0;
    for (int c = 0; c < N_CORES; c++) begin
      if (core_q == CW'(c)) begin
        live_mask  = quota_mask_i[c*N_COUNTERS +: N_COUNTERS];
        live_limit = quota_limit_i[c*SW +: SW];
        for (int i = 0; i < N_COUNTERS; i++) begin
          if (idx_q == IW'(i)) begin
            live_value = counter_value_i[(c*N_COUNTERS+i)*REG_WIDTH +: REG_WIDTH];
          end
        end
      end
    end
    for (int i = 0; i < N_COUNTERS; i++) begin
      if (idx_q == IW'(i)) begin
        mask_bit = mask_q[i];
      end
    end
  end

  // A mask edit mid-evaluation invalidates the partial sum for this core
  assign mask_chg   = (live_mask != mask_q);
  assign over_limit = (acc_q > live_limit);
  assign core_inc   = (core_q == LAST_CORE) ? '0 : core_q + CW'(1);
`ifdef PMU_QUOTA_SKIP_EMPTY_EN
  assign mask_empty = (live_mask == '0);
`endif

  // State and datapath registers; soft reset mirrors the async reset values
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      core_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      mask_q  <= '0;
      intr_q  <= '0;
    end else if (softrst_i) begin
      state_q <= S_IDLE;
      core_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      mask_q  <= '0;
      intr_q  <= '0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      intr_q  <= intr_d;
    end
  end

  // Next-state logic: sequencing of state, core and counter index
  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        core_d = '0;
        idx_d  = '0;
        if (en_i) begin
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        idx_d   = '0;
        state_d = S_ACC;
`ifdef PMU_QUOTA_SKIP_EMPTY_EN
        if (mask_empty) begin
          if (en_i) begin
            state_d = S_CLR;
            core_d  = core_inc;
          end else begin
            state_d = S_IDLE;
            core_d  = '0;
          end
        end
`endif
      end
      S_ACC: begin
        if (mask_chg) begin
          state_d = S_CLR;
        end else begin
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            state_d = S_CMP;
          end
        end
      end
      S_CMP: begin
        if (mask_chg) begin
          state_d = S_CLR;
        end else if (en_i) begin
          state_d = S_CLR;
          core_d  = core_inc;
        end else begin
          state_d = S_IDLE;
          core_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs and datapath: accumulate, compare, sticky interrupt, sweep pulse
  always_comb begin
    acc_d        = acc_q;
    mask_d       = mask_q;
    intr_d       = intr_q & ~intr_clr_i;
    sweep_done_o = 1'b0;
    case (state_q)
      S_CLR: begin
        acc_d  = '0;
        mask_d = live_mask;
`ifdef PMU_QUOTA_SKIP_EMPTY_EN
        if (mask_empty && (core_q == LAST_CORE)) begin
          sweep_done_o = 1'b1;
        end
`endif
      end
      S_ACC: begin
        if (mask_bit) begin
          acc_d = acc_q + SW'(live_value);
        end
      end
      S_CMP: begin
        if (!mask_chg) begin
          // Set is applied after the clear so a coincident clear loses
          for (int c = 0; c < N_CORES; c++) begin
            if (over_limit && (core_q == CW'(c))) begin
              intr_d[c] = 1'b1;
            end
          end
          if (core_q == LAST_CORE) begin
            sweep_done_o = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign intr_quota_o = intr_q;
  assign cur_core_o   = core_q;

endmodule
`default_nettype wire

// File: tb/tb_pmu_quota_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmu_quota_sched
// Brief    : Self-checking bench for pmu_quota_sched. The reference derives
//            each core's time slot and sum directly from the masks, counters
//            and limits, then checks every cycle of a sweep against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmu_quota_sched;

  localparam int W  = 32;
  localparam int N  = 9;
  localparam int C  = 4;
  localparam int SW = $clog2(N) + W;
  localparam int CW = ($clog2(C) > 1) ? $clog2(C) : 1;
  localparam int P  = N + 2;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              softrst_i = 1'b0;
  logic              en_i = 1'b0;
  logic [C*N*W-1:0]  counter_value_i = '0;
  logic [C*N-1:0]    quota_mask_i = '0;
  logic [C*SW-1:0]   quota_limit_i = '0;
  logic [C-1:0]      intr_clr_i = '0;
  logic [C-1:0]      intr_quota_o;
  logic [CW-1:0]     cur_core_o;
  logic              sweep_done_o;

  pmu_quota_sched #(.REG_WIDTH(W), .N_COUNTERS(N), .N_CORES(C)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .softrst_i       (softrst_i),
    .en_i            (en_i),
    .counter_value_i (counter_value_i),
    .quota_mask_i    (quota_mask_i),
    .quota_limit_i   (quota_limit_i),
    .intr_clr_i      (intr_clr_i),
    .intr_quota_o    (intr_quota_o),
    .cur_core_o      (cur_core_o),
    .sweep_done_o    (sweep_done_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference state
  longint unsigned m_cnt[C][N];
  logic [N-1:0]    m_mask[C];
  longint unsigned m_lim[C];
  logic [C-1:0]    exp_intr = '0;
  int              n_cmp = 0;
  int              n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive();
    for (int c = 0; c < C; c++) begin
      for (int i = 0; i < N; i++) begin
        counter_value_i[(c*N+i)*W +: W] = W'(m_cnt[c][i]);
      end
      quota_mask_i[c*N +: N]    = m_mask[c];
      quota_limit_i[c*SW +: SW] = SW'(m_lim[c]);
    end
  endtask

  task automatic set_all(input longint unsigned val, input logic [N-1:0] msk,
                         input longint unsigned lim);
    for (int c = 0; c < C; c++) begin
      for (int i = 0; i < N; i++) m_cnt[c][i] = val;
      m_mask[c] = msk;
      m_lim[c]  = lim;
    end
  endtask

  function automatic longint unsigned msum(input int c);
    longint unsigned s = 0;
    for (int i = 0; i < N; i++) if (m_mask[c][i]) s += m_cnt[c][i];
    return s;
  endfunction

  function automatic bit hit(input int c);
    return msum(c) > m_lim[c];
  endfunction

  function automatic int core_len(input int c);
`ifdef PMU_QUOTA_SKIP_EMPTY_EN
    if (m_mask[c] == '0) return 1;
`endif
    return P;
  endfunction

  function automatic int sweep_len();
    int s = 0;
    for (int c = 0; c < C; c++) s += core_len(c);
    return s;
  endfunction

  task automatic soft_reset();
    en_i       = 1'b0;
    intr_clr_i = '0;
    softrst_i  = 1'b1;
    tick();
    softrst_i  = 1'b0;
    exp_intr   = '0;
  endtask

  task automatic go_idle();
    en_i       = 1'b0;
    intr_clr_i = '0;
    repeat (30) tick();
    soft_reset();
  endtask

  // One full sweep from IDLE; core slots are laid out back to back
  task automatic run_sweep(input string tag);
    int start[C];
    int total;
    int cc;
    logic [C-1:0] e;
    total = 0;
    for (int c = 0; c < C; c++) begin
      start[c] = total;
      total += core_len(c);
    end
    en_i = 1'b1;
    for (int t = 0; t < total; t++) begin
      tick();
      cc = 0;
      for (int c = 0; c < C; c++) if (t >= start[c]) cc = c;
      e = exp_intr;
      for (int c = 0; c < C; c++) if (hit(c) && (t > start[c] + core_len(c) - 1)) e[c] = 1'b1;
      chk({tag, "_core"}, cur_core_o, cc);
      chk({tag, "_done"}, sweep_done_o, (t == total - 1));
      chk({tag, "_intr"}, intr_quota_o, e);
      if (t == total - 1) en_i = 1'b0;
    end
    for (int c = 0; c < C; c++) if (hit(c)) exp_intr[c] = 1'b1;
    tick();
    chk({tag, "_idle_core"}, cur_core_o, 0);
    chk({tag, "_idle_done"}, sweep_done_o, 0);
    chk({tag, "_final_intr"}, intr_quota_o, exp_intr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    longint unsigned s;

    // Reset values
    rstn_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_intr", intr_quota_o, 0);
    chk("rst_core", cur_core_o, 0);
    chk("rst_done", sweep_done_o, 0);
    rstn_i = 1'b1;
    tick();

    // Limit 89 on core 2 trips with a sum of 90; 90 does not
    set_all(10, '1, 90);
    m_lim[2] = 89;
    drive();
    run_sweep("q89");
    chk("q89_vec", intr_quota_o, 4'b0100);
    soft_reset();
    set_all(10, '1, 90);
    drive();
    run_sweep("q90");
    chk("q90_vec", intr_quota_o, 4'b0000);

    // Saturated counters: no wrap in the accumulator
    soft_reset();
    set_all(64'hFFFF_FFFF, '1, 9 * 64'hFFFF_FFFF - 1);
    drive();
    run_sweep("sat");
    chk("sat_vec", intr_quota_o, 4'b1111);
    soft_reset();
    set_all(64'hFFFF_FFFF, '1, 9 * 64'hFFFF_FFFF);
    drive();
    run_sweep("sat_eq");

    // Sweep period with enable held
    soft_reset();
    set_all(10, '1, 1000);
    drive();
    en_i = 1'b1;
    k = 0;
    while (!sweep_done_o && k < 200) begin tick(); k++; end
    chk("spc_first", sweep_done_o, 1);
    for (int r = 0; r < 2; r++) begin
      k = 0;
      do begin tick(); k++; end while (!sweep_done_o && k < 200);
      chk("spc_period", k, sweep_len());
    end
    tick();
    chk("spc_wrap_core", cur_core_o, 0);
    go_idle();

    // Coincident clear loses to set; late clear wins; enable fall finishes core
    set_all(10, '1, 1000);
    m_lim[0] = 0;
    m_lim[1] = 5;
    drive();
    en_i = 1'b1;
    for (int t = 0; t <= 30; t++) begin
      tick();
      if (t == 10) begin
        chk("clr_cmp_core", cur_core_o, 0);
        chk("clr_pre", intr_quota_o, 0);
        intr_clr_i = 4'b0001;
      end
      if (t == 11) chk("clr_set_wins", intr_quota_o, 4'b0001);
      if (t == 12) begin
        chk("clr_later", intr_quota_o, 4'b0000);
        intr_clr_i = '0;
      end
      if (t == 15) en_i = 1'b0;
      if (t == 21) chk("enf_cmp_core", cur_core_o, 1);
      if (t == 22) begin
        chk("enf_idle_core", cur_core_o, 0);
        chk("enf_intr", intr_quota_o, 4'b0010);
      end
      if (t == 30) begin
        chk("enf_stay_core", cur_core_o, 0);
        chk("enf_stay_intr", intr_quota_o, 4'b0010);
      end
    end
    soft_reset();

    // Mask edit at the 5th ACC cycle of core 1 restarts that core
    set_all(10, '1, 1000);
    m_lim[1] = 50;
    drive();
    en_i = 1'b1;
    for (int t = 0; t <= 49; t++) begin
      tick();
      if (t == 16) begin
        chk("mc_acc_core", cur_core_o, 1);
        m_mask[1] = 9'h1F8;
        drive();
      end
      if (t == 17) chk("mc_restart_core", cur_core_o, 1);
      if (t == 22) begin
        chk("mc_still_core1", cur_core_o, 1);
        chk("mc_intr_held", intr_quota_o, 0);
      end
      if (t == 27) chk("mc_intr_pre", intr_quota_o, 0);
      if (t == 28) begin
        chk("mc_intr_set", intr_quota_o, 4'b0010);
        chk("mc_next_core", cur_core_o, 2);
      end
      if (t == 48) chk("mc_not_done", sweep_done_o, 0);
      if (t == 49) begin
        chk("mc_done", sweep_done_o, 1);
        en_i = 1'b0;
      end
    end
    go_idle();

    // Asynchronous reset mid-sweep
    set_all(10, '1, 0);
    drive();
    en_i = 1'b1;
    repeat (15) tick();
    chk("ar_pre", intr_quota_o, 4'b0001);
    rstn_i = 1'b0;
    #2;
    chk("ar_intr", intr_quota_o, 0);
    chk("ar_core", cur_core_o, 0);
    en_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    tick();
    soft_reset();

    // Soft reset mid-sweep overrides enable and restarts from core 0
    set_all(10, '1, 0);
    drive();
    en_i = 1'b1;
    for (int t = 0; t <= 28; t++) begin
      tick();
      if (t == 15) begin
        chk("sr_pre", intr_quota_o, 4'b0001);
        softrst_i = 1'b1;
      end
      if (t == 16) begin
        chk("sr_intr", intr_quota_o, 0);
        chk("sr_core", cur_core_o, 0);
        chk("sr_done", sweep_done_o, 0);
        softrst_i = 1'b0;
      end
      if (t == 27) chk("sr_cmp_pre", intr_quota_o, 0);
      if (t == 28) chk("sr_restart_set", intr_quota_o, 4'b0001);
    end
    go_idle();

    // Empty-mask core
    set_all(10, '1, 50);
    m_mask[1] = '0;
    drive();
    run_sweep("skip");

    // Randomized rounds; interrupts accumulate across odd rounds
    for (int r = 0; r < 8; r++) begin
      if (r % 2 == 0) soft_reset();
      for (int c = 0; c < C; c++) begin
        for (int i = 0; i < N; i++) begin
          m_cnt[c][i] = ($urandom_range(0, 3) == 0) ? longint'($urandom) : longint'($urandom_range(0, 50));
        end
        m_mask[c] = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
        s = msum(c);
        case ($urandom_range(0, 3))
          0:       m_lim[c] = s;
          1:       m_lim[c] = (s == 0) ? 0 : s - 1;
          2:       m_lim[c] = s + 1;
          default: m_lim[c] = {$urandom, $urandom} & ((64'd1 << SW) - 1);
        endcase
      end
      drive();
      run_sweep($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
